// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters,
// combinational visible-area flag and registered sync/colour/frame outputs.
// Sync, colour and frame_start come out one clk after the counters, so
// rgb_out lines up with hsync/vsync at the DAC.
module vga_sync_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [2:0] rgb_in,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       p_tick,
   output logic       video_on,
   output logic       frame_start,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb_out
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0]       HS_FIRST = 10'(H_DISPLAY + H_FP);
   localparam logic [9:0]       HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam logic [9:0]       VS_FIRST = 10'(V_DISPLAY + V_FP);
   localparam logic [9:0]       VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_cnt_q, h_cnt_d;
   logic [9:0]       v_cnt_q, v_cnt_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic [2:0]       rgb_q, rgb_d;
   logic             frame_start_q, frame_start_d;
   logic             line_end, frame_end;

   // Pixel tick and visible-area flag, straight from the current counters.
   always_comb begin
      p_tick    = en && (div_q == DIV_MAX);
      video_on  = en && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      line_end  = (h_cnt_q == H_MAX);
      frame_end = line_end && (v_cnt_q == V_MAX);
   end

   // Next-state for divider and counters; dropping en parks everything at (0,0).
   always_comb begin
      div_d   = div_q;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!en) begin
         div_d   = '0;
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (p_tick) begin
         div_d = '0;
         if (line_end) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_MAX) ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Stage-2 values: sync windows, blanked colour, and the frame wrap marker.
   // frame_start only fires on a real wrap, so an en restart never pulses it.
   always_comb begin
      hsync_d       = ~(en && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
      vsync_d       = ~(en && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
      rgb_d         = video_on ? rgb_in : 3'b000;
      frame_start_d = p_tick && frame_end;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         div_q   <= div_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Output stage registers, inactive levels in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= 3'b000;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pixel_x     = h_cnt_q;
   assign pixel_y     = v_cnt_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb_out     = rgb_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a compact timing so whole frames fit in a short
// run. Two instances share the stimulus: one divides by 3, one by 1.
// The reference derives everything from the count of enabled clocks t.
module tb_vga_sync_gen;

   localparam int HD = 20, HF = 4, HS = 6, HB = 5, HT = HD + HF + HS + HB;
   localparam int VD = 10, VF = 2, VS = 3, VB = 4, VT = VD + VF + VS + VB;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0;
   logic [2:0] rgb_in = 3'b000;

   logic [9:0] px [2];
   logic [9:0] py [2];
   logic       pt [2];
   logic       vo [2];
   logic       fs [2];
   logic       hs [2];
   logic       vs [2];
   logic [2:0] ro [2];

   logic [9:0] e_x [2];
   logic [9:0] e_y [2];
   logic       e_pt [2];
   logic       e_vo [2];
   logic       e_fs [2];
   logic       e_hs [2];
   logic       e_vs [2];
   logic [2:0] e_ro [2];

   int tests = 0;
   int fails = 0;
   int t = 0;

   always #5 clk = ~clk;

   vga_sync_gen #(.H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .CLK_DIV(3)) u_div3 (
      .clk(clk), .reset_n(reset_n), .en(en), .rgb_in(rgb_in),
      .pixel_x(px[0]), .pixel_y(py[0]), .p_tick(pt[0]), .video_on(vo[0]),
      .frame_start(fs[0]), .hsync(hs[0]), .vsync(vs[0]), .rgb_out(ro[0]));

   vga_sync_gen #(.H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .CLK_DIV(1)) u_div1 (
      .clk(clk), .reset_n(reset_n), .en(en), .rgb_in(rgb_in),
      .pixel_x(px[1]), .pixel_y(py[1]), .p_tick(pt[1]), .video_on(vo[1]),
      .frame_start(fs[1]), .hsync(hs[1]), .vsync(vs[1]), .rgb_out(ro[1]));

   function automatic int dv(input int k);
      return (k == 0) ? 3 : 1;
   endfunction

   // Position of instance k after tt enabled clocks.
   function automatic int hpos(input int k, input int tt);
      return (tt / dv(k)) % HT;
   endfunction

   function automatic int vpos(input int k, input int tt);
      return (tt / (dv(k) * HT)) % VT;
   endfunction

   task automatic comb_model();
      for (int k = 0; k < 2; k++) begin
         e_x[k]  = 10'(hpos(k, t));
         e_y[k]  = 10'(vpos(k, t));
         e_vo[k] = en && (hpos(k, t) < HD) && (vpos(k, t) < VD);
         e_pt[k] = en && ((t % dv(k)) == dv(k) - 1);
      end
   endtask

   task automatic reset_model();
      t = 0;
      for (int k = 0; k < 2; k++) begin
         e_hs[k] = 1'b1;
         e_vs[k] = 1'b1;
         e_ro[k] = 3'b000;
         e_fs[k] = 1'b0;
      end
      comb_model();
   endtask

   // One clk: advance the reference across the edge, return at the negedge.
   task automatic step();
      logic       en_p  = en;
      logic [2:0] rgb_p = rgb_in;
      int         t_p   = t;
      int         h_p, v_p, d;
      @(posedge clk);
      if (!reset_n) begin
         reset_model();
      end else begin
         for (int k = 0; k < 2; k++) begin
            d = dv(k);
            h_p = hpos(k, t_p);
            v_p = vpos(k, t_p);
            e_hs[k] = !(en_p && h_p >= HD + HF && h_p < HD + HF + HS);
            e_vs[k] = !(en_p && v_p >= VD + VF && v_p < VD + VF + VS);
            e_ro[k] = (en_p && h_p < HD && v_p < VD) ? rgb_p : 3'b000;
            e_fs[k] = en_p && (((t_p + 1) % (d * HT * VT)) == 0);
         end
         t = en_p ? t_p + 1 : 0;
      end
      @(negedge clk);
      comb_model();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      en = 1'b0;
      reset_model();
      for (int i = 0; i < 3; i++) step();
      for (int k = 0; k < 2; k++) begin
         tests++; if (px[k] !== 10'd0) begin fails++; $display("FAIL reset_px[%0d] got %0d exp 0", k, px[k]); end
         tests++; if (py[k] !== 10'd0) begin fails++; $display("FAIL reset_py[%0d] got %0d exp 0", k, py[k]); end
         tests++; if (hs[k] !== 1'b1) begin fails++; $display("FAIL reset_hs[%0d] got %b exp 1", k, hs[k]); end
         tests++; if (vs[k] !== 1'b1) begin fails++; $display("FAIL reset_vs[%0d] got %b exp 1", k, vs[k]); end
         tests++; if (ro[k] !== 3'b000) begin fails++; $display("FAIL reset_rgb[%0d] got %b exp 000", k, ro[k]); end
         tests++; if (fs[k] !== 1'b0) begin fails++; $display("FAIL reset_fs[%0d] got %b exp 0", k, fs[k]); end
         tests++; if (pt[k] !== 1'b0) begin fails++; $display("FAIL reset_pt[%0d] got %b exp 0", k, pt[k]); end
      end
      reset_n = 1'b1;
      en = 1'b1;
      comb_model();
   endtask

   task automatic test_counting();
      for (int i = 0; i < 3 * HT * 3 + 10; i++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            tests++; if (px[k] !== e_x[k]) begin fails++; $display("FAIL cnt_px[%0d] t=%0d got %0d exp %0d", k, t, px[k], e_x[k]); end
            tests++; if (py[k] !== e_y[k]) begin fails++; $display("FAIL cnt_py[%0d] t=%0d got %0d exp %0d", k, t, py[k], e_y[k]); end
            tests++; if (pt[k] !== e_pt[k]) begin fails++; $display("FAIL cnt_pt[%0d] t=%0d got %b exp %b", k, t, pt[k], e_pt[k]); end
            tests++; if (vo[k] !== e_vo[k]) begin fails++; $display("FAIL cnt_vo[%0d] t=%0d got %b exp %b", k, t, vo[k], e_vo[k]); end
         end
      end
   endtask

   task automatic test_free_run();
      int t0 = t;
      int n_fs = 0;
      int n_hs_low = 0;
      int frame = 3 * HT * VT;
      for (int i = 0; i < 2 * frame + 20; i++) begin
         rgb_in = 3'($urandom_range(0, 7));
         step();
         if (fs[0] === 1'b1) n_fs++;
         if (hs[0] === 1'b0) n_hs_low++;
         for (int k = 0; k < 2; k++) begin
            tests++; if (px[k] !== e_x[k]) begin fails++; $display("FAIL run_px[%0d] t=%0d got %0d exp %0d", k, t, px[k], e_x[k]); end
            tests++; if (py[k] !== e_y[k]) begin fails++; $display("FAIL run_py[%0d] t=%0d got %0d exp %0d", k, t, py[k], e_y[k]); end
            tests++; if (hs[k] !== e_hs[k]) begin fails++; $display("FAIL run_hs[%0d] t=%0d got %b exp %b", k, t, hs[k], e_hs[k]); end
            tests++; if (vs[k] !== e_vs[k]) begin fails++; $display("FAIL run_vs[%0d] t=%0d got %b exp %b", k, t, vs[k], e_vs[k]); end
            tests++; if (ro[k] !== e_ro[k]) begin fails++; $display("FAIL run_rgb[%0d] t=%0d got %b exp %b", k, t, ro[k], e_ro[k]); end
            tests++; if (fs[k] !== e_fs[k]) begin fails++; $display("FAIL run_fs[%0d] t=%0d got %b exp %b", k, t, fs[k], e_fs[k]); end
            tests++; if (vo[k] !== e_vo[k]) begin fails++; $display("FAIL run_vo[%0d] t=%0d got %b exp %b", k, t, vo[k], e_vo[k]); end
         end
      end
      tests++;
      if (n_fs !== (t / frame) - (t0 / frame)) begin
         fails++; $display("FAIL run_fs_count got %0d exp %0d", n_fs, (t / frame) - (t0 / frame));
      end
      // Every line holds hsync low for HS pixels of 3 clk each.
      tests++;
      if (n_hs_low < 2 * VT * HS * 3 - HS * 3 || n_hs_low > 2 * VT * HS * 3 + HS * 3) begin
         fails++; $display("FAIL run_hs_low_clks got %0d exp about %0d", n_hs_low, 2 * VT * HS * 3);
      end
   endtask

   task automatic test_en_drop();
      for (int r = 0; r < 4; r++) begin
         int n = (r == 0) ? ((7 * HT + 15) * 3) : $urandom_range(50, 1500);
         for (int i = 0; i < n; i++) begin
            rgb_in = 3'($urandom_range(0, 7));
            step();
         end
         en = 1'b0;
         step();
         for (int k = 0; k < 2; k++) begin
            tests++; if (px[k] !== 10'd0 || py[k] !== 10'd0) begin fails++; $display("FAIL drop_xy[%0d] got %0d,%0d exp 0,0", k, px[k], py[k]); end
            tests++; if (vo[k] !== 1'b0) begin fails++; $display("FAIL drop_vo[%0d] got %b exp 0", k, vo[k]); end
         end
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) step();
         for (int k = 0; k < 2; k++) begin
            tests++; if (hs[k] !== 1'b1 || vs[k] !== 1'b1) begin fails++; $display("FAIL drop_sync[%0d] got %b%b exp 11", k, hs[k], vs[k]); end
            tests++; if (ro[k] !== 3'b000) begin fails++; $display("FAIL drop_rgb[%0d] got %b exp 000", k, ro[k]); end
         end
         en = 1'b1;
         comb_model();
         for (int i = 0; i < 2 * HT * 3; i++) begin
            rgb_in = 3'b110;
            step();
            for (int k = 0; k < 2; k++) begin
               tests++; if (px[k] !== e_x[k] || py[k] !== e_y[k]) begin fails++; $display("FAIL resume_xy[%0d] t=%0d got %0d,%0d exp %0d,%0d", k, t, px[k], py[k], e_x[k], e_y[k]); end
               tests++; if (fs[k] !== e_fs[k]) begin fails++; $display("FAIL resume_fs[%0d] t=%0d got %b exp %b", k, t, fs[k], e_fs[k]); end
               tests++; if (ro[k] !== e_ro[k]) begin fails++; $display("FAIL resume_rgb[%0d] t=%0d got %b exp %b", k, t, ro[k], e_ro[k]); end
               tests++; if (hs[k] !== e_hs[k] || vs[k] !== e_vs[k]) begin fails++; $display("FAIL resume_sync[%0d] t=%0d got %b%b exp %b%b", k, t, hs[k], vs[k], e_hs[k], e_vs[k]); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      for (int i = 0; i < 3 * HT * VT + 10 && !found; i++) begin
         step();
         if (hpos(0, t) == 26 && vpos(0, t) == 13) found = 1;
      end
      tests++;
      if (!found) begin fails++; $display("FAIL mid_reach got 0 exp 1"); end
      tests++;
      if (hs[0] !== e_hs[0] || vs[0] !== e_vs[0]) begin
         fails++; $display("FAIL mid_presync got %b%b exp %b%b", hs[0], vs[0], e_hs[0], e_vs[0]);
      end
      reset_n = 1'b0;
      #1;
      reset_model();
      for (int k = 0; k < 2; k++) begin
         tests++; if (px[k] !== 10'd0 || py[k] !== 10'd0) begin fails++; $display("FAIL mid_xy[%0d] got %0d,%0d exp 0,0", k, px[k], py[k]); end
         tests++; if (hs[k] !== 1'b1 || vs[k] !== 1'b1) begin fails++; $display("FAIL mid_sync[%0d] got %b%b exp 11", k, hs[k], vs[k]); end
         tests++; if (ro[k] !== 3'b000 || fs[k] !== 1'b0) begin fails++; $display("FAIL mid_rgbfs[%0d] got %b %b exp 000 0", k, ro[k], fs[k]); end
      end
      step();
      step();
      reset_n = 1'b1;
      comb_model();
      for (int i = 0; i < 3 * HT * VT + 10; i++) begin
         rgb_in = 3'($urandom_range(0, 7));
         step();
         for (int k = 0; k < 2; k++) begin
            tests++; if (px[k] !== e_x[k] || py[k] !== e_y[k]) begin fails++; $display("FAIL post_xy[%0d] t=%0d got %0d,%0d exp %0d,%0d", k, t, px[k], py[k], e_x[k], e_y[k]); end
            tests++; if (hs[k] !== e_hs[k] || vs[k] !== e_vs[k]) begin fails++; $display("FAIL post_sync[%0d] t=%0d got %b%b exp %b%b", k, t, hs[k], vs[k], e_hs[k], e_vs[k]); end
            tests++; if (ro[k] !== e_ro[k] || fs[k] !== e_fs[k]) begin fails++; $display("FAIL post_rgbfs[%0d] t=%0d got %b %b exp %b %b", k, t, ro[k], fs[k], e_ro[k], e_fs[k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_counting();
      test_free_run();
      test_en_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 Parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical front porch, sync and back porch widths in lines.
REQ-005 Parameter CLK_DIV, default 2, clk cycles per pixel (>=1).
REQ-006 clk  input  1  system clock; reset_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  timing enable; low synchronously clears and blanks.
REQ-008 rgb_in  input  3  pixel colour from the graphics subsystem for the current pixel_x/pixel_y.
REQ-009 pixel_x  output  10  current horizontal count; pixel_y  output  10  current vertical count.
REQ-010 p_tick  output  1  one-clk pulse marking the last clk of each pixel period.
REQ-011 video_on  output  1  current pixel_x/pixel_y lies inside the visible area.
REQ-012 frame_start  output  1  one-clk pulse on the first clk of count (0,0).
REQ-013 hsync, vsync  output  1 each  active-low sync pulses to the monitor.
REQ-014 rgb_out  output  3  blanked colour to the DAC, aligned with hsync/vsync.

Function
REQ-015 H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
REQ-016 Divider counts 0..CLK_DIV-1 while en=1; p_tick = en && (div == CLK_DIV-1), combinational from div; CLK_DIV=1 gives p_tick=en.
REQ-017 On p_tick, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 wraps to 0 on that same tick.
REQ-018 pixel_x = h_cnt, pixel_y = v_cnt, driven directly from the counter registers (no added latency).
REQ-019 video_on = en && h_cnt < H_DISPLAY && v_cnt < V_DISPLAY, combinational.
REQ-020 Stage-2 registers (one clk after the counters): hsync <= ~(en && h_cnt in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1]), i.e. low for 656..751.
REQ-021 vsync <= ~(en && v_cnt in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1]), i.e. low for lines 490..491.
REQ-022 rgb_out <= video_on ? rgb_in : 3'b000, registered every clk; latency to pixel_x/pixel_y is exactly 1 clk.
REQ-023 frame_start is a registered pulse, high for exactly one clk when counters first hold (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-024 en=0: next clk div, h_cnt, v_cnt cleared to 0, frame_start 0; hsync/vsync/rgb_out take the inactive values 1/1/000 on the following stage-2 update.
REQ-025 en 0->1: counting resumes from (0,0), div 0; no frame_start pulse for this restart.
REQ-026 Counters never exceed H_TOTAL-1 / V_TOTAL-1; all arithmetic 10 bits, no overflow for defaults.

Reset
REQ-027 reset_n low asynchronously forces div=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, rgb_out=000, frame_start=0.
REQ-028 Reset asserted mid-frame takes effect immediately, without waiting for clk; after release counting starts at (0,0) on the first clk with en=1.

Verification
REQ-029 Reset release, en=1, CLK_DIV=2 -> p_tick every 2nd clk; pixel_x 0..799 then 0; pixel_y becomes 1 after 1600 clk.
REQ-030 Free run -> hsync low exactly 192 clk per line, first low 1 clk after pixel_x becomes 656; vsync low for 2 lines (3200 clk) starting at line 490.
REQ-031 Free run -> frame_start pulses once every 840000 clk, one clk wide, in the first clk of (0,0).
REQ-032 rgb_in=3'b110 constant -> rgb_out=110 during visible, 000 for pixel_x 640..799 and pixel_y 480..524, 1 clk after the counters.
REQ-033 en dropped at (300,200) -> next clk pixel_x=pixel_y=0, video_on=0, then hsync=vsync=1, rgb_out=000; en raised -> count restarts at (0,0), no frame_start.
REQ-034 reset_n pulsed at (700,495) -> outputs immediately at reset values; after release hsync/vsync=1 until the normal sync windows.
